// File: rtl/dmem_store_bridge_pkg.sv
// Shared types and constants for the data-memory store bridge.
package dmem_bridge_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/dmem_store_bridge_if.sv
// Core-side load/store port and external memory bus, bundled for the bridge.
interface dmem_store_bridge_if;
  import dmem_bridge_pkg::*;

  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] data;
  logic              writeEnabled;
  logic [ADDR_W-1:0] readAddress;
  logic              readEnabled;
  logic [DATA_W-1:0] out;
  logic              stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  writeAddress, data, writeEnabled, readAddress, readEnabled,
    input  bus_ack, bus_rdata,
    output out, stall, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output writeAddress, data, writeEnabled, readAddress, readEnabled,
    output bus_ack, bus_rdata,
    input  out, stall, bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/dmem_store_bridge_store_buffer.sv
// In-order posted-store FIFO with a youngest-first word-address lookup.
module store_buffer
  import dmem_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  entry_t                   push_entry_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:WORD_LSB] lookup_word_i,
  output logic                     full_o,
  output logic                     empty_o,
  output entry_t                   head_o,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        hit_data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] idx_s;
  logic             match_s;

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx_s      = '0;
    match_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s      = head_q + PTR_W'(i);
      match_s    = (i < int'(count_q)) &&
                   (mem_q[idx_s].addr[ADDR_W-1:WORD_LSB] == lookup_word_i);
      hit_data_o = match_s ? mem_q[idx_s].data : hit_data_o;
      hit_o      = hit_o | match_s;
    end
  end

endmodule

// File: rtl/dmem_store_bridge.sv
// Data-memory bridge: posts stores into a buffer, forwards loads from it,
// and arbitrates buffer drains and load misses onto a single memory bus.
module dmem_store_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_store_bridge_if.slave  bridge_if
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              load_done_q, load_done_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic              full_s, empty_s, buf_hit_s, push_s, pop_s;
  logic              inc_hit_s, hit_s, miss_s, stall_s;
  logic [DATA_W-1:0] buf_data_s, fwd_data_s;
  entry_t            head_s;
  entry_t            push_entry_s;

  assign push_s       = bridge_if.writeEnabled & ~full_s;
  assign push_entry_s = '{addr: bridge_if.writeAddress, data: bridge_if.data};

  store_buffer #(.DEPTH(DEPTH)) u_sb (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_s),
    .push_entry_i  (push_entry_s),
    .pop_i         (pop_s),
    .lookup_word_i (bridge_if.readAddress[ADDR_W-1:WORD_LSB]),
    .full_o        (full_s),
    .empty_o       (empty_s),
    .head_o        (head_s),
    .hit_o         (buf_hit_s),
    .hit_data_o    (buf_data_s)
  );

  // The store presented this cycle is younger than anything buffered.
  assign inc_hit_s  = bridge_if.writeEnabled &&
                      (bridge_if.writeAddress[ADDR_W-1:WORD_LSB] ==
                       bridge_if.readAddress[ADDR_W-1:WORD_LSB]);
  assign fwd_data_s = inc_hit_s ? bridge_if.data : buf_data_s;
  assign hit_s      = bridge_if.readEnabled & (inc_hit_s | buf_hit_s);
  assign miss_s     = bridge_if.readEnabled & ~hit_s & ~load_done_q;
  assign stall_s    = reset & ((bridge_if.writeEnabled & full_s) | miss_s);

  // Next-state, bus launch and load-result selection.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    pop_s       = 1'b0;
    if (hit_s) begin
      out_d = fwd_data_s;
    end else begin
      out_d = out_q;
    end
    if (load_done_q && !stall_s) begin
      load_done_d = 1'b0;
    end else begin
      load_done_d = load_done_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (miss_s) begin
          state_d    = ST_READ;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = bridge_if.readAddress;
        end else if (!empty_s) begin
          state_d     = ST_WRITE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = head_s.addr;
          bus_wdata_d = head_s.data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bridge_if.bus_ack) begin
          pop_s     = 1'b1;
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (bridge_if.bus_ack) begin
          out_d       = bridge_if.bus_rdata;
          load_done_d = 1'b1;
          bus_req_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State, load result and bus registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      load_done_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      load_done_q <= load_done_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign bridge_if.out       = out_q;
  assign bridge_if.stall     = stall_s;
  assign bridge_if.bus_req   = bus_req_q;
  assign bridge_if.bus_we    = bus_we_q;
  assign bridge_if.bus_addr  = bus_addr_q;
  assign bridge_if.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_store_bridge.sv
// Directed bench for dmem_store_bridge: forwarding, buffer-full stall,
// miss timing, write-before-read ordering and reset mid-read.
module tb_dmem_store_bridge;
  import dmem_bridge_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_store_bridge_if bif ();

  dmem_store_bridge #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bridge_if (bif)
  );

  int total = 0;
  int bad   = 0;

  logic        ack_en      = 1'b0;
  int          wait_cycles = 0;
  int          wait_cnt    = 0;
  logic [31:0] rd_data     = 32'h0;
  logic [31:0] wl_addr[$];
  logic [31:0] wl_data[$];

  // Memory responder: acks after wait_cycles idle-request cycles, logs writes.
  initial begin
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bif.bus_req && ack_en && !bif.bus_ack) begin
        if (wait_cnt == wait_cycles) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rd_data;
          wait_cnt      = 0;
          if (bif.bus_we) begin
            wl_addr.push_back(bif.bus_addr);
            wl_data.push_back(bif.bus_wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        bif.bus_ack = 1'b0;
        if (!bif.bus_req) wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] oa, od;
    if (wl_addr.size() > 0) begin
      oa = wl_addr.pop_front();
      od = wl_data.pop_front();
    end else begin
      oa = 'x;
      od = 'x;
    end
    chk({tag, "_addr"}, oa, ea);
    chk({tag, "_data"}, od, ed);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic core(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic re, input logic [31:0] ra);
    bif.writeEnabled = we;
    bif.writeAddress = wa;
    bif.data         = wd;
    bif.readEnabled  = re;
    bif.readAddress  = ra;
  endtask

  initial begin
    core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // reset state
    nxt(); nxt(); neg();
    chk("rst_out", bif.out, 32'h0);
    chk("rst_stall", 32'(bif.stall), 32'h0);
    chk("rst_req", 32'(bif.bus_req), 32'h0);
    chk("rst_we", 32'(bif.bus_we), 32'h0);
    chk("rst_addr", bif.bus_addr, 32'h0);
    chk("rst_wdata", bif.bus_wdata, 32'h0);
    nxt();
    reset = 1'b1;

    // store then forwarded load before the drain
    ack_en = 1'b1; wait_cycles = 0;
    core(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    neg(); chk("t1_st_stall", 32'(bif.stall), 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    neg(); chk("t1_ld_stall", 32'(bif.stall), 32'h0);
    chk("t1_ld_noreq", 32'(bif.bus_req), 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    neg(); chk("t1_out", bif.out, 32'hDEADBEEF);
    chk("t1_req", 32'(bif.bus_req), 32'h1);
    chk("t1_is_write", 32'(bif.bus_we), 32'h1);
    chk("t1_addr", bif.bus_addr, 32'h100);
    nxt();
    chk_wr("t1_wr", 32'h100, 32'hDEADBEEF);

    // same-cycle store wins over buffered older store; youngest buffered wins
    ack_en = 1'b0;
    core(1'b1, 32'h104, 32'h22, 1'b0, 32'h0);
    neg(); chk("t2_st_stall", 32'(bif.stall), 32'h0);
    nxt(); core(1'b1, 32'h104, 32'h11, 1'b1, 32'h104);
    neg(); chk("t2_fwd_stall", 32'(bif.stall), 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b1, 32'h106);
    neg(); chk("t2_same_cycle", bif.out, 32'h11);
    chk("t2_ld2_stall", 32'(bif.stall), 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    neg(); chk("t2_youngest", bif.out, 32'h11);
    chk("t2_head_addr", bif.bus_addr, 32'h104);
    chk("t2_head_data", bif.bus_wdata, 32'h22);
    nxt(); ack_en = 1'b1;
    repeat (6) nxt();
    chk_wr("t2_wr0", 32'h104, 32'h22);
    chk_wr("t2_wr1", 32'h104, 32'h11);

    // buffer full: fifth store stalls until the first pop
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core(1'b1, 32'h300 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
      neg(); chk("t3_fill_stall", 32'(bif.stall), 32'h0);
      nxt();
    end
    core(1'b1, 32'h310, 32'h5, 1'b0, 32'h0);
    neg(); chk("t3_full", 32'(bif.stall), 32'h1);
    nxt(); ack_en = 1'b1;
    neg(); chk("t3_full_pop_cycle", 32'(bif.stall), 32'h1);
    nxt();
    neg(); chk("t3_accept", 32'(bif.stall), 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (12) nxt();
    for (int i = 0; i < 5; i++) begin
      chk_wr("t3_order", 32'h300 + 32'(4 * i), 32'(i + 1));
    end

    // load miss with three wait cycles
    wait_cycles = 3; rd_data = 32'hCAFE0001;
    core(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++) begin
      neg(); chk("t4_stall", 32'(bif.stall), 32'h1);
      if (i == 1) begin
        chk("t4_req", 32'(bif.bus_req), 32'h1);
        chk("t4_is_read", 32'(bif.bus_we), 32'h0);
        chk("t4_addr", bif.bus_addr, 32'h200);
      end
      nxt();
    end
    neg(); chk("t4_release", 32'(bif.stall), 32'h0);
    chk("t4_out", bif.out, 32'hCAFE0001);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // miss during an in-flight write: write completes, idle gap, then read
    wait_cycles = 2; rd_data = 32'h5A5A0500;
    core(1'b1, 32'h400, 32'h55, 1'b0, 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b1, 32'h500);
    neg(); chk("t5_stall", 32'(bif.stall), 32'h1);
    chk("t5_wr_we", 32'(bif.bus_we), 32'h1);
    chk("t5_wr_addr", bif.bus_addr, 32'h400);
    nxt(); nxt(); nxt();
    neg(); chk("t5_idle_gap", 32'(bif.bus_req), 32'h0);
    chk("t5_gap_stall", 32'(bif.stall), 32'h1);
    nxt();
    neg(); chk("t5_rd_req", 32'(bif.bus_req), 32'h1);
    chk("t5_rd_we", 32'(bif.bus_we), 32'h0);
    chk("t5_rd_addr", bif.bus_addr, 32'h500);
    nxt(); nxt();
    neg(); chk("t5_wait_stall", 32'(bif.stall), 32'h1);
    nxt();
    neg(); chk("t5_release", 32'(bif.stall), 32'h0);
    chk("t5_out", bif.out, 32'h5A5A0500);
    chk_wr("t5_wr", 32'h400, 32'h55);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // reset asserted mid-read discards the read and the buffered store
    ack_en = 1'b0;
    core(1'b1, 32'h700, 32'h77, 1'b1, 32'h600);
    neg(); chk("t6_stall", 32'(bif.stall), 32'h1);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b1, 32'h600);
    neg(); chk("t6_req", 32'(bif.bus_req), 32'h1);
    chk("t6_is_read", 32'(bif.bus_we), 32'h0);
    chk("t6_addr", bif.bus_addr, 32'h600);
    nxt(); reset = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bif.bus_req), 32'h0);
    chk("t6_rst_stall", 32'(bif.stall), 32'h0);
    chk("t6_rst_out", bif.out, 32'h0);
    core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    nxt(); nxt();
    reset = 1'b1; ack_en = 1'b1; wait_cycles = 0; rd_data = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("t6_no_drain", 32'(bif.bus_req), 32'h0);
      nxt();
    end
    core(1'b0, 32'h0, 32'h0, 1'b1, 32'h800);
    neg(); chk("t6_miss_stall", 32'(bif.stall), 32'h1);
    nxt();
    neg(); chk("t6_miss_req", 32'(bif.bus_req), 32'h1);
    chk("t6_miss_addr", bif.bus_addr, 32'h800);
    nxt();
    neg(); chk("t6_miss_release", 32'(bif.stall), 32'h0);
    chk("t6_miss_out", bif.out, 32'h12345678);
    nxt(); core(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    nxt();
    chk("t6_no_writes", 32'(wl_addr.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_store_bridge.md
# dmem_store_bridge

Data-memory responder sitting between the core's data-memory port and an external single-ported memory bus. The core side keeps the existing separate write and read ports (writeAddress/data/writeEnabled, readAddress/readEnabled/out); stores are posted into a small in-order store buffer and drained to the bus in the background. Loads are served by store-to-load forwarding when they hit a buffered store, and by a bus read otherwise, with `stall` holding the core while a miss or a full buffer is resolved.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (full-word accesses only)
- DEPTH, 4, store-buffer entries, power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- writeAddress  in  ADDR_W  store address
- data  in  DATA_W  store data
- writeEnabled  in  1  store request this cycle
- readAddress  in  ADDR_W  load address
- readEnabled  in  1  load request this cycle
- out  out  DATA_W  load result, registered
- stall  out  1  core must hold all request inputs stable while high
- bus_req  out  1  bus transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  transaction complete (sampled while bus_req=1)
- bus_rdata  in  DATA_W  read data, valid with bus_ack on a read

## Operation
- Reset (reset=0, async): buffer empty, state IDLE, load_done=0; out, stall, bus_req, bus_we, bus_addr, bus_wdata all 0. Buffered, undrained stores are discarded; an in-flight bus_req drops immediately.
- Match uses word address bits [ADDR_W-1:2]; bits [1:0] ignored.
- Store accept: writeEnabled & !full → push {writeAddress, data}. writeEnabled & full → stall=1, nothing pushed. `full` is the registered count==DEPTH; a pop in the same cycle does not clear it.
- Load lookup, priority: (1) the incoming store this cycle (writeEnabled & match); (2) buffer entries youngest→oldest. On a hit, out ← forwarded data at the next edge, no stall.
- Load miss: stall=1 combinationally until load_done. A miss bypasses buffered stores, which is safe because no buffered store has a matching address.
- FSM states:
  - IDLE: a pending load miss takes priority → READ; else if the buffer is non-empty → WRITE (drive head entry); else stay.
  - WRITE: bus_req=1, bus_we=1, addr/wdata = head. On bus_ack, pop head → IDLE.
  - READ: bus_req=1, bus_we=0, addr = readAddress. On bus_ack, out ← bus_rdata, load_done←1 → IDLE.
- bus_req and all bus fields are registered and stay stable until bus_ack. After each ack, bus_req is low for ≥1 cycle (the IDLE cycle).
- load_done clears on the edge after stall drops (the load is consumed). A store arriving while a write is in flight only pushes; it never preempts the write.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- `stall` = (writeEnabled & full) | (readEnabled & !hit & !load_done).

## Timing
- Hit load: request at cycle N, out valid from N+1, stall stays 0.
- Miss from IDLE with zero-wait ack:
  - N: stall=1.
  - N+1: bus_req=1, ack.
  - N+2: out valid, stall=0.
  - Each wait cycle adds 1.
- Miss during WRITE: the write completes first. READ is issued the cycle after IDLE.
- Drain throughput: one entry per 2 cycles with zero-wait ack.
- Store accept latency: 0 (pushed at the edge of the request cycle when not full).

## Structure
- Package `dmem_bridge_pkg`:
  - state enum typedef {ST_IDLE, ST_WRITE, ST_READ}
  - entry struct {addr, data}
  - WORD_LSB=2 constant
- Sub-module `store_buffer`:
  - circular FIFO with head/tail pointers and count
  - full/empty flags
  - combinational youngest-first match lookup returning hit + data
- Top level holds the FSM, the forwarding mux, stall logic and the bus registers.

## Test plan
- Store 0x100←0xDEADBEEF, then load 0x100 before the drain → out=0xDEADBEEF at N+1, stall never high, no bus read issued.
- Same-cycle store 0x104←0x11 and load 0x104 (buffer already holds 0x104←0x22) → out=0x11.
- Push 5 stores, DEPTH=4, bus_ack held 0 → stall=1 on the 5th; raise ack → 5th accepted after the first pop; bus writes occur in order.
- Load miss 0x200, memory returns 0xCAFE0001 after 3 wait cycles → stall high for 5 cycles, out=0xCAFE0001, bus_we=0.
- Load miss while a write is in flight → write ack first, then one IDLE cycle, then the read; out correct.
- Assert reset mid-READ → bus_req=0 and stall=0 immediately, count=0; after release, a load miss proceeds normally.
